// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA serial capture block.
//   H_PIXELS       : pixels captured per line
//   BYTES_PER_LINE : packed bytes per captured line
//   V_LINES        : captured lines per frame
//   ADDR_W         : width of the byte address bus
//   LAST_ADDR      : highest byte address within one frame
//   cap_state_e    : capture FSM state encoding
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_PIXELS       = 512;
  localparam int BYTES_PER_LINE = H_PIXELS / 8;
  localparam int V_LINES        = 342;
  localparam int ADDR_W         = 15;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_LINE * V_LINES - 1);

  typedef enum logic [1:0] {
    FRAME_WAIT,
    LINE_WAIT,
    H_SKIP,
    ACTIVE
  } cap_state_e;

endpackage

// File: rtl/vga_deser8.sv
// ---------------------------------------------------------------------------
// vga_deser8
// Serial-to-byte packer. Each enabled cycle shifts bit_i into the LSB; every
// 8th enabled cycle raises done_o combinationally, with byte_o holding the
// finished byte (first bit in bit 7) in that same cycle.
//   clk        : sample clock, rising edge
//   nReset     : asynchronous active-low reset
//   clr_i      : synchronous discard of a partial byte
//   shift_en_i : shift bit_i in this cycle
//   bit_i      : serial data bit
//   byte_o     : current 8-bit window {stored bits, bit_i}
//   done_o     : byte complete strobe
// ---------------------------------------------------------------------------
module vga_deser8 (
  input  logic       clk,
  input  logic       nReset,
  input  logic       clr_i,
  input  logic       shift_en_i,
  input  logic       bit_i,
  output logic [7:0] byte_o,
  output logic       done_o
);

  // Only seven bits need storage: the eighth is the live input bit, which
  // lets the byte be handed off in the same cycle it completes.
  logic [6:0] sr_q;
  logic [2:0] cnt_q;

  assign byte_o = {sr_q, bit_i};
  assign done_o = shift_en_i && (cnt_q == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en_i) begin
      sr_q  <= byte_o[6:0];
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/vga_shift_in.sv
// ---------------------------------------------------------------------------
// vga_shift_in
// Captures a serial monochrome VGA stream into packed bytes and presents
// them on a simple request/acknowledge write port.
//   Parameters: H_OFFSET (pixEn cycles skipped after line start),
//               V_OFFSET (line starts skipped after frame start)
//   clk, nReset        : clock, asynchronous active-low reset
//   pixEn, serIn       : pixel enable and serial pixel bit
//   nHsync, nVsync     : active-low syncs (already synchronized)
//   wrAck              : sink accepts the pending write this cycle
//   clrOvf             : clear sticky overflow
//   wrData, wrAddr     : packed byte and its address (line*64 + byte)
//   wrReq              : write pending, held until acknowledged
//   ovf                : sticky overflow (byte dropped while busy)
//   frameActive        : high across the captured lines of a frame
// ---------------------------------------------------------------------------
module vga_shift_in
  import vga_pkg::*;
#(
  parameter int unsigned H_OFFSET = 0,
  parameter int unsigned V_OFFSET = 0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              pixEn,
  input  logic              serIn,
  input  logic              nHsync,
  input  logic              nVsync,
  input  logic              wrAck,
  input  logic              clrOvf,
  output logic [7:0]        wrData,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              wrReq,
  output logic              ovf,
  output logic              frameActive
);

  localparam logic [15:0] H_OFF_L = H_OFFSET[15:0];
  localparam logic [15:0] V_OFF_L = V_OFFSET[15:0];

  cap_state_e        state_q;
  logic              nhs_q, nvs_q;
  logic [8:0]        line_q;
  logic [15:0]       vskip_q;
  logic [15:0]       hskip_q;
  logic [5:0]        byte_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_req_q;
  logic              ovf_q;
  logic              frame_act_q;

  logic       hs_rise, vs_fall;
  logic       shift_en;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       ovf_set;

  // Edges compare the live sync against its one-cycle history, on every clk.
  assign hs_rise = nHsync & ~nhs_q;
  assign vs_fall = ~nVsync & nvs_q;

  // A frame restart in the same cycle as a pixel discards that pixel too.
  assign shift_en = (state_q == ACTIVE) && pixEn && !vs_fall;

  vga_deser8 u_deser (
    .clk        (clk),
    .nReset     (nReset),
    .clr_i      (vs_fall),
    .shift_en_i (shift_en),
    .bit_i      (serIn),
    .byte_o     (byte_val),
    .done_o     (byte_done)
  );

  // A byte that completes while the previous one is still unaccepted is lost.
  assign ovf_set = byte_done && wr_req_q && !wrAck;

  // NOTE: asynchronous reset puts every register, including the outputs,
  // into a known state immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= FRAME_WAIT;
      nhs_q       <= 1'b1;
      nvs_q       <= 1'b1;
      line_q      <= '0;
      vskip_q     <= '0;
      hskip_q     <= '0;
      byte_idx_q  <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_req_q    <= 1'b0;
      ovf_q       <= 1'b0;
      frame_act_q <= 1'b0;
    end else begin
      nhs_q <= nHsync;
      nvs_q <= nVsync;

      // Capture sequencing. A vsync fall restarts the frame from any state;
      // the write port is deliberately left alone so a pending byte survives.
      if (vs_fall) begin
        state_q     <= LINE_WAIT;
        line_q      <= '0;
        vskip_q     <= '0;
        hskip_q     <= '0;
        byte_idx_q  <= '0;
        addr_q      <= '0;
        frame_act_q <= 1'b0;
      end else begin
        case (state_q)
          FRAME_WAIT: ;
          LINE_WAIT: begin
            if (hs_rise) begin
              if (vskip_q != V_OFF_L) begin
                vskip_q <= vskip_q + 16'd1;
              end else begin
                frame_act_q <= 1'b1;
                hskip_q     <= '0;
                state_q     <= (H_OFFSET == 0) ? ACTIVE : H_SKIP;
              end
            end
          end
          H_SKIP: begin
            if (pixEn) begin
              if (hskip_q == H_OFF_L - 16'd1) state_q <= ACTIVE;
              else                            hskip_q <= hskip_q + 16'd1;
            end
          end
          ACTIVE: begin
            // Hsync is ignored here; the line ends on its pixel count alone.
            if (byte_done) begin
              byte_idx_q <= byte_idx_q + 6'd1;
              if (byte_idx_q == 6'(BYTES_PER_LINE - 1)) begin
                if (line_q == 9'(V_LINES - 1)) begin
                  state_q     <= FRAME_WAIT;
                  frame_act_q <= 1'b0;
                end else begin
                  line_q  <= line_q + 9'd1;
                  state_q <= LINE_WAIT;
                end
              end
            end
          end
          default: state_q <= FRAME_WAIT;
        endcase
      end

      // Write port. The address advances for every completed byte, dropped
      // or not, so a later byte still lands at its true position.
      if (byte_done) begin
        if (!wr_req_q || wrAck) begin
          wr_data_q <= byte_val;
          wr_addr_q <= addr_q;
          wr_req_q  <= 1'b1;
        end
        if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end else if (wrAck) begin
        wr_req_q <= 1'b0;
      end

      // Setting wins over clearing in the same cycle.
      if (ovf_set)     ovf_q <= 1'b1;
      else if (clrOvf) ovf_q <= 1'b0;
    end
  end

  assign wrData      = wr_data_q;
  assign wrAddr      = wr_addr_q;
  assign wrReq       = wr_req_q;
  assign ovf         = ovf_q;
  assign frameActive = frame_act_q;

endmodule

// File: tb/tb_vga_shift_in.sv
// ---------------------------------------------------------------------------
// tb_vga_shift_in
// Two instances: dut0 with zero offsets, dut1 with H_OFFSET=3, V_OFFSET=2.
// Inputs are shared; 'sel' picks which instance the scoreboard watches.
// Expected writes are queued by the stimulus and popped by a monitor on
// every accepted write (wrReq && wrAck).
// ---------------------------------------------------------------------------
module tb_vga_shift_in;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic nReset = 1'b1;
  logic pixEn = 1'b0, serIn = 1'b0;
  logic nHsync = 1'b1, nVsync = 1'b1;
  logic wrAck = 1'b1, clrOvf = 1'b0;

  logic [7:0]        wd0, wd1;
  logic [ADDR_W-1:0] wa0, wa1;
  logic              wr0, wr1, ovf0, ovf1, fa0, fa1;

  vga_shift_in dut0 (
    .clk(clk), .nReset(nReset), .pixEn(pixEn), .serIn(serIn),
    .nHsync(nHsync), .nVsync(nVsync), .wrAck(wrAck), .clrOvf(clrOvf),
    .wrData(wd0), .wrAddr(wa0), .wrReq(wr0), .ovf(ovf0), .frameActive(fa0)
  );

  vga_shift_in #(.H_OFFSET(3), .V_OFFSET(2)) dut1 (
    .clk(clk), .nReset(nReset), .pixEn(pixEn), .serIn(serIn),
    .nHsync(nHsync), .nVsync(nVsync), .wrAck(wrAck), .clrOvf(clrOvf),
    .wrData(wd1), .wrAddr(wa1), .wrReq(wr1), .ovf(ovf1), .frameActive(fa1)
  );

  always #5 clk = ~clk;

  logic              sel = 1'b0;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] waddr;
  logic              wreq, wovf, wfa;
  assign wdata = sel ? wd1  : wd0;
  assign waddr = sel ? wa1  : wa0;
  assign wreq  = sel ? wr1  : wr0;
  assign wovf  = sel ? ovf1 : ovf0;
  assign wfa   = sel ? fa1  : fa0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               mon_e;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_wr  = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (nReset && wreq && wrAck) begin
      n_wr++;
      last_addr = waddr;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%02h, expected no write", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (waddr !== mon_e.addr || wdata !== mon_e.data) begin
          n_bad++;
          $display("FAIL write: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                   waddr, wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] pat(input int mode, input int line, input int b);
    if (mode == 0) return 8'hA5;
    return 8'(line * 5 + b * 3 + 29);
  endfunction

  // Eight pixels, MSB first; ackm[i] is wrAck during pixel i of the byte.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] ackm);
    for (int i = 0; i < 8; i++) begin
      pixEn = 1'b1;
      serIn = d[7-i];
      wrAck = ackm[i];
      tick();
    end
  endtask

  task automatic hpulse();
    pixEn  = 1'b0;
    nHsync = 1'b0;
    tick();
    tick();
    nHsync = 1'b1;
    tick();
  endtask

  task automatic vpulse();
    pixEn  = 1'b0;
    nVsync = 1'b0;
    tick();
    tick();
    nVsync = 1'b1;
    tick();
  endtask

  // One line: hoff filler pixels (all ones), then 64 pattern bytes.
  task automatic cap_line(input int line, input int hoff, input bit expect_wr, input int base);
    logic [7:0] d;
    hpulse();
    for (int k = 0; k < hoff; k++) begin
      pixEn = 1'b1;
      serIn = 1'b1;
      wrAck = 1'b1;
      tick();
    end
    for (int b = 0; b < BYTES_PER_LINE; b++) begin
      d = pat(1, line, b);
      if (expect_wr) push_exp(base + b, d);
      send_byte(d, 8'hFF);
    end
    pixEn = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // ---- reset state ----
    #2 nReset = 1'b0;
    tick();
    check("rst_wrReq", wreq, 0);
    check("rst_wrData", wdata, 0);
    check("rst_wrAddr", waddr, 0);
    check("rst_ovf", wovf, 0);
    check("rst_frameActive", wfa, 0);
    nReset = 1'b1;
    tick();

    // ---- line 0 of 0xA5, wrAck high: 64 writes, wrReq one cycle after 8th pixel ----
    vpulse();
    hpulse();
    for (int b = 0; b < BYTES_PER_LINE; b++) begin
      push_exp(b, pat(0, 0, b));
      send_byte(pat(0, 0, b), 8'hFF);
      check("a5_wrReq_latency", wreq, 1);
      check("a5_wrAddr", waddr, b);
    end
    pixEn = 1'b0;
    check("a5_frameActive", wfa, 1);
    drain("a5_all_written");

    // ---- overflow: ack low for 9 pixEn cycles after the first byte ----
    vpulse();
    hpulse();
    push_exp(0, 8'h3C);
    send_byte(8'h3C, 8'h00);
    send_byte(8'h81, 8'h00);
    check("ovf_set", wovf, 1);
    check("ovf_hold_data", wdata, 8'h3C);
    check("ovf_hold_addr", waddr, 0);
    push_exp(2, 8'h5E);
    send_byte(8'h5E, 8'hFE);
    check("ovf_next_addr", waddr, 2);
    for (int b = 3; b < BYTES_PER_LINE; b++) begin
      push_exp(b, pat(1, 9, b));
      send_byte(pat(1, 9, b), 8'hFF);
    end
    pixEn = 1'b0;
    tick();
    check("ovf_sticky", wovf, 1);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    check("ovf_cleared", wovf, 0);
    drain("ovf_all_written");

    // ---- ack arrives in the cycle the next byte completes ----
    vpulse();
    hpulse();
    push_exp(0, 8'h11);
    send_byte(8'h11, 8'hFF);
    push_exp(1, 8'h22);
    send_byte(8'h22, 8'h80);
    check("b2b_wrReq", wreq, 1);
    check("b2b_wrData", wdata, 8'h22);
    check("b2b_wrAddr", waddr, 1);
    check("b2b_no_ovf", wovf, 0);
    push_exp(2, 8'h33);
    send_byte(8'h33, 8'hFF);
    pixEn = 1'b0;
    drain("b2b_all_written");

    // ---- vsync fall at pixel 100 of line 5 ----
    vpulse();
    for (int l = 0; l < 5; l++) cap_line(l, 0, 1'b1, l * BYTES_PER_LINE);
    hpulse();
    for (int b = 0; b < 12; b++) begin
      push_exp(5 * BYTES_PER_LINE + b, pat(1, 5, b));
      send_byte(pat(1, 5, b), 8'hFF);
    end
    for (int k = 0; k < 4; k++) begin
      pixEn = 1'b1;
      serIn = k[0];
      tick();
    end
    nVsync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pixEn = 1'b1;
      serIn = 1'b1;
      tick();
    end
    pixEn  = 1'b0;
    nVsync = 1'b1;
    tick();
    cap_line(0, 0, 1'b1, 0);
    drain("abort_all_written");

    // ---- reset pulse mid-line with wrReq high ----
    hpulse();
    send_byte(8'hC3, 8'h00);
    for (int k = 0; k < 3; k++) begin
      pixEn = 1'b1;
      serIn = 1'b0;
      tick();
    end
    check("pre_rst_wrReq", wreq, 1);
    #2 nReset = 1'b0;
    #1;
    check("midrst_wrReq", wreq, 0);
    check("midrst_wrData", wdata, 0);
    check("midrst_wrAddr", waddr, 0);
    check("midrst_frameActive", wfa, 0);
    pixEn = 1'b0;
    wrAck = 1'b1;
    tick();
    nReset = 1'b1;
    tick();
    cap_line(1, 0, 1'b0, 0);
    check("post_rst_idle", wreq, 0);
    vpulse();
    cap_line(2, 0, 1'b1, 0);
    drain("post_rst_all_written");

    // ---- full frame on dut1: H_OFFSET=3, V_OFFSET=2 ----
    sel    = 1'b1;
    nReset = 1'b0;
    tick();
    check("f_rst_wrReq", wreq, 0);
    nReset = 1'b1;
    tick();
    vpulse();
    n_wr = 0;
    cap_line(100, 3, 1'b0, 0);
    cap_line(101, 3, 1'b0, 0);
    check("f_skip_frameActive", wfa, 0);
    for (int l = 0; l < V_LINES; l++) begin
      cap_line(l, 3, 1'b1, l * BYTES_PER_LINE);
      if (l == 0)           check("f_first_frameActive", wfa, 1);
      if (l == V_LINES - 2) check("f_mid_frameActive", wfa, 1);
    end
    check("f_end_frameActive", wfa, 0);
    drain("f_all_written");
    check("f_write_count", n_wr, BYTES_PER_LINE * V_LINES);
    check("f_last_addr", last_addr, BYTES_PER_LINE * V_LINES - 1);
    check("f_no_ovf", wovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
